// File: rtl/render_fetch_scheduler_pkg.sv
// render_fetch_scheduler_pkg: shared cell layout, display geometry and fetch FSM states.
package render_fetch_scheduler_pkg;
  localparam int CELL_SHIFT  = 3;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int V_TOTAL     = 525;
  localparam int GRID_W      = H_ACTIVE >> CELL_SHIFT;
  localparam int GRID_H      = V_ACTIVE >> CELL_SHIFT;
  localparam int SIGNAL_bits = 8;
  localparam int CELL_bits   = SIGNAL_bits + 3;
  typedef struct packed {
    logic                   ant;
    logic                   sugar;
    logic                   nest;
    logic [SIGNAL_bits-1:0] chem;
  } cell_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/render_line_buffer.sv
// render_line_buffer: one grid row of cells, single write port, registered read port.
module render_line_buffer #(
  parameter int DEPTH = 80,
  parameter int W     = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  input  logic                     clr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  // Only the read register is reset; it drives the render outputs directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= clr_i ? '0 : mem_q[raddr_i];
  end
endmodule

// File: rtl/render_fetch_scheduler.sv
// render_fetch_scheduler: shares the grid RAM between row prefetch for display and the sim engine.
module render_fetch_scheduler #(
  parameter int CELL_SHIFT = render_fetch_scheduler_pkg::CELL_SHIFT,
  parameter int H_ACTIVE   = render_fetch_scheduler_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = render_fetch_scheduler_pkg::V_ACTIVE,
  parameter int V_TOTAL    = render_fetch_scheduler_pkg::V_TOTAL,
  parameter int GRID_W     = H_ACTIVE >> CELL_SHIFT,
  parameter int GRID_H     = V_ACTIVE >> CELL_SHIFT,
  parameter int ADDR_bits  = $clog2(GRID_W * GRID_H)
) (
  input  logic                                             Clk,
  input  logic                                             Reset_n,
  input  logic [9:0]                                       DrawX,
  input  logic [9:0]                                       DrawY,
  input  logic                                             vga_blank,
  input  logic                                             line_pulse,
  input  logic                                             sim_req,
  input  logic                                             sim_we,
  input  logic [ADDR_bits-1:0]                             sim_addr,
  input  logic [render_fetch_scheduler_pkg::CELL_bits-1:0] sim_wdata,
  output logic                                             sim_gnt,
  output logic                                             sim_rvalid,
  output logic [render_fetch_scheduler_pkg::CELL_bits-1:0] sim_rdata,
  output logic [ADDR_bits-1:0]                             ram_addr,
  output logic                                             ram_we,
  output logic [render_fetch_scheduler_pkg::CELL_bits-1:0] ram_wdata,
  input  logic [render_fetch_scheduler_pkg::CELL_bits-1:0] ram_rdata,
  output logic                                             renderAnt,
  output logic                                             renderSugar,
  output logic                                             renderNest,
  output logic [render_fetch_scheduler_pkg::SIGNAL_bits-1:0] renderChem,
  output logic                                             fetch_overrun
);
  import render_fetch_scheduler_pkg::*;
  localparam int IDX_W = $clog2(GRID_W);
  fetch_state_t   state_q;
  logic [IDX_W-1:0]     col_q;
  logic [ADDR_bits-1:0] base_q;
  logic                 overrun_q, rvalid_q;
  logic [9:0]           tgt;
  logic                 start, lb_we;
  logic [CELL_bits-1:0] lb_rdata;
  cell_t                px;
  assign tgt   = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
  assign start = line_pulse && (tgt < 10'(V_ACTIVE)) && (tgt[CELL_SHIFT-1:0] == '0);
  // Display fetch always wins; a qualifying pulse blocks the sim in the same cycle.
  assign sim_gnt    = Reset_n && sim_req && (state_q == IDLE) && !start;
  assign ram_addr   = (state_q == FETCH) ? base_q + ADDR_bits'(col_q) : sim_gnt ? sim_addr : '0;
  assign ram_we     = sim_gnt && sim_we;
  assign ram_wdata  = sim_gnt ? sim_wdata : '0;
  assign sim_rvalid = rvalid_q;
  assign sim_rdata  = rvalid_q ? ram_rdata : '0;
  assign fetch_overrun = overrun_q;
  // Read data lags its address by one cycle, so it lands at col-1 (DRAIN catches the last word).
  assign lb_we = ((state_q == FETCH) && (col_q != '0)) || (state_q == DRAIN);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      base_q    <= '0;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= sim_gnt && !sim_we;
      if (start) begin
        state_q <= FETCH;
        col_q   <= '0;
        base_q  <= (tgt == '0) ? '0 : base_q + ADDR_bits'(GRID_W);
        if (state_q != IDLE) overrun_q <= 1'b1;
      end else if (state_q == FETCH) begin
        col_q <= col_q + 1'b1;
        if (col_q == IDX_W'(GRID_W - 1)) state_q <= DRAIN;
      end else if (state_q == DRAIN) begin
        state_q <= IDLE;
      end
    end
  end
  render_line_buffer #(
    .DEPTH(GRID_W),
    .W    (CELL_bits)
  ) u_line_buffer (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .we_i   (lb_we),
    .waddr_i(col_q - 1'b1),
    .wdata_i(ram_rdata),
    .raddr_i(IDX_W'(DrawX >> CELL_SHIFT)),
    .clr_i  (vga_blank),
    .rdata_o(lb_rdata)
  );
  assign px          = cell_t'(lb_rdata);
  assign renderAnt   = px.ant;
  assign renderSugar = px.sugar;
  assign renderNest  = px.nest;
  assign renderChem  = px.chem;
endmodule

// File: tb/tb_render_fetch_scheduler.sv
// tb_render_fetch_scheduler: directed checks of row prefetch, arbitration, display stream, overrun and reset.
module tb_render_fetch_scheduler;
  import render_fetch_scheduler_pkg::*;
  logic                   Clk = 1'b0;
  logic                   Reset_n = 1'b0;
  logic [9:0]             DrawX = '0, DrawY = '0;
  logic                   vga_blank = 1'b1, line_pulse = 1'b0;
  logic                   sim_req = 1'b0, sim_we = 1'b0;
  logic [12:0]            sim_addr = '0;
  logic [CELL_bits-1:0]   sim_wdata = '0;
  logic                   sim_gnt, sim_rvalid, ram_we;
  logic [CELL_bits-1:0]   sim_rdata, ram_wdata, ram_rdata;
  logic [12:0]            ram_addr;
  logic                   renderAnt, renderSugar, renderNest, fetch_overrun;
  logic [SIGNAL_bits-1:0] renderChem;
  logic [CELL_bits-1:0]   mem [8192];
  int checks = 0, errors = 0;

  render_fetch_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .vga_blank(vga_blank),
    .line_pulse(line_pulse), .sim_req(sim_req), .sim_we(sim_we), .sim_addr(sim_addr),
    .sim_wdata(sim_wdata), .sim_gnt(sim_gnt), .sim_rvalid(sim_rvalid), .sim_rdata(sim_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .renderAnt(renderAnt), .renderSugar(renderSugar), .renderNest(renderNest),
    .renderChem(renderChem), .fetch_overrun(fetch_overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] y);
    @(negedge Clk);
    DrawY = y;
    line_pulse = 1'b1;
    @(negedge Clk);
    line_pulse = 1'b0;
  endtask

  initial begin
    int lowc;
    for (int i = 0; i < 8192; i++) mem[i] = CELL_bits'(i);
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_sim_gnt", sim_gnt, 0);
    chk("rst_sim_rvalid", sim_rvalid, 0);
    chk("rst_sim_rdata", sim_rdata, 0);
    chk("rst_overrun", fetch_overrun, 0);
    chk("rst_render", {renderAnt, renderSugar, renderNest, renderChem}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // First-row fetch: line 524 pulse targets row 0
    pulse(10'd524);
    for (int i = 0; i < 80; i++) begin
      #1;
      chk("t1_fetch_addr", ram_addr, i);
      chk("t1_fetch_we", ram_we, 0);
      @(negedge Clk);
    end
    #1;
    chk("t1_drain_addr", ram_addr, 0);
    @(negedge Clk);
    DrawY = 10'd0;
    vga_blank = 1'b0;
    DrawX = 10'd16;
    @(negedge Clk);
    #1;
    chk("t1_chem_x16", renderChem, 2);
    chk("t1_ant_x16", renderAnt, 0);
    DrawX = 10'd632;
    @(negedge Clk);
    #1;
    chk("t1_chem_x632", renderChem, 79);
    DrawX = 10'd8;
    vga_blank = 1'b1;
    @(negedge Clk);
    #1;
    chk("t1_blank_zero", renderChem, 0);

    // Row advance and ignored pulses
    pulse(10'd7);
    #1;
    chk("t2_base80", ram_addr, 80);
    repeat (81) @(negedge Clk);
    pulse(10'd15);
    #1;
    chk("t2_base160", ram_addr, 160);
    repeat (81) @(negedge Clk);
    @(negedge Clk);
    DrawY = 10'd6;
    line_pulse = 1'b1;
    sim_req = 1'b1;
    sim_we = 1'b0;
    sim_addr = 13'd5;
    #1;
    chk("t2_y6_gnt", sim_gnt, 1);
    chk("t2_y6_addr", ram_addr, 5);
    @(negedge Clk);
    DrawY = 10'd479;
    sim_addr = 13'd7;
    #1;
    chk("t2_y6_rvalid", sim_rvalid, 1);
    chk("t2_y6_rdata", sim_rdata, 5);
    chk("t2_y479_gnt", sim_gnt, 1);
    chk("t2_y479_addr", ram_addr, 7);
    @(negedge Clk);
    line_pulse = 1'b0;
    sim_req = 1'b0;
    #1;
    chk("t2_y479_rdata", sim_rdata, 7);

    // Arbitration: held sim read across a fetch
    @(negedge Clk);
    DrawY = 10'd23;
    line_pulse = 1'b1;
    sim_req = 1'b1;
    sim_addr = 13'd42;
    #1;
    chk("t3_tie_gnt", sim_gnt, 0);
    lowc = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      line_pulse = 1'b0;
      #1;
      if (sim_gnt) break;
      lowc++;
    end
    chk("t3_wait_cycles", lowc, 82);
    chk("t3_gnt_addr", ram_addr, 42);
    @(negedge Clk);
    sim_req = 1'b0;
    #1;
    chk("t3_rvalid", sim_rvalid, 1);
    chk("t3_rdata", sim_rdata, 42);

    // Sim write then display of row 1
    @(negedge Clk);
    sim_req = 1'b1;
    sim_we = 1'b1;
    sim_addr = 13'd81;
    sim_wdata = 11'h400;
    #1;
    chk("t4_gnt", sim_gnt, 1);
    chk("t4_we", ram_we, 1);
    chk("t4_addr", ram_addr, 81);
    chk("t4_wdata", ram_wdata, 11'h400);
    @(negedge Clk);
    sim_req = 1'b0;
    sim_we = 1'b0;
    #1;
    chk("t4_no_rvalid", sim_rvalid, 0);
    pulse(10'd524);
    repeat (81) @(negedge Clk);
    pulse(10'd7);
    #1;
    chk("t4_row1_addr", ram_addr, 80);
    repeat (81) @(negedge Clk);
    DrawY = 10'd8;
    vga_blank = 1'b0;
    DrawX = 10'd8;
    @(negedge Clk);
    #1;
    chk("t4_ant", renderAnt, 1);
    chk("t4_ant_chem", renderChem, 0);
    DrawX = 10'd16;
    @(negedge Clk);
    #1;
    chk("t4_x16_chem", renderChem, 82);
    chk("t4_x16_ant", renderAnt, 0);
    vga_blank = 1'b1;

    // Overrun: second qualifying pulse 40 cycles into a fetch
    pulse(10'd15);
    #1;
    chk("t5_pre_overrun", fetch_overrun, 0);
    chk("t5_base160", ram_addr, 160);
    repeat (39) @(negedge Clk);
    DrawY = 10'd23;
    line_pulse = 1'b1;
    @(negedge Clk);
    line_pulse = 1'b0;
    #1;
    chk("t5_overrun", fetch_overrun, 1);
    chk("t5_restart_addr", ram_addr, 240);

    // Async reset mid-fetch
    repeat (10) @(negedge Clk);
    vga_blank = 1'b0;
    DrawX = 10'd16;
    @(negedge Clk);
    #1;
    chk("t6_pre_chem", renderChem, 242);
    chk("t6_pre_addr", ram_addr, 251);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_addr", ram_addr, 0);
    chk("t6_rst_we", ram_we, 0);
    chk("t6_rst_render", {renderAnt, renderSugar, renderNest, renderChem}, 0);
    chk("t6_rst_overrun", fetch_overrun, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    vga_blank = 1'b1;
    @(negedge Clk);
    #1;
    chk("t6_idle_addr", ram_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/render_fetch_scheduler.md
# render_fetch_scheduler

Shares the single-port cell-state RAM between the simulation engine and the display path. On each horizontal blank that precedes a new grid row, it prefetches that row of cells into an internal line buffer. During active video it streams per-pixel render flags from the buffer to `color_mapper`. Sits between the grid RAM, the sim update engine and the VGA controller / `color_mapper`.

## Interface
Parameters:
- `CELL_SHIFT`, default 3: log2 of cell edge in pixels (8×8-pixel cells).
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines.
- `V_TOTAL`, default 525: total lines per frame.
- `GRID_W`, default `H_ACTIVE>>CELL_SHIFT` (80): cells per grid row.
- `GRID_H`, default `V_ACTIVE>>CELL_SHIFT` (60): grid rows.
- `ADDR_bits`, default `$clog2(GRID_W*GRID_H)` (13): RAM address width.

Ports (clock and reset first):
- `Clk` in 1: single system clock. All logic is on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `DrawX` in 10: current pixel column from the VGA controller.
- `DrawY` in 10: current line.
- `vga_blank` in 1: 1 during horizontal or vertical blanking.
- `line_pulse` in 1: 1-cycle pulse at the start of each horizontal blank. `DrawY` is valid when it fires.
- `sim_req` in 1: sim engine requests a RAM access.
- `sim_we` in 1: 1 = write, 0 = read.
- `sim_addr` in `ADDR_bits`: sim access address.
- `sim_wdata` in `CELL_bits`: sim write data.
- `sim_gnt` out 1: the sim access is performed this cycle.
- `sim_rvalid` out 1: `sim_rdata` is valid. Asserted the cycle after a granted read.
- `sim_rdata` out `CELL_bits`: read data for the sim engine.
- `ram_addr` out `ADDR_bits`: grid RAM address.
- `ram_we` out 1: grid RAM write enable.
- `ram_wdata` out `CELL_bits`: grid RAM write data.
- `ram_rdata` in `CELL_bits`: grid RAM read data. Synchronous, 1-cycle read latency.
- `renderAnt` out 1: to `color_mapper`.
- `renderSugar` out 1: to `color_mapper`.
- `renderNest` out 1: to `color_mapper`.
- `renderChem` out `SIGNAL_bits`: to `color_mapper`.
- `fetch_overrun` out 1: sticky error flag.

## Operation
- Cell word layout `cell_t` = {ant, sugar, nest, chem[SIGNAL_bits-1:0]}. `CELL_bits` = `SIGNAL_bits` + 3.
- Target line on `line_pulse`:
  - `tgt` = 0 if `DrawY` == `V_TOTAL`-1, else `DrawY`+1.
  - A fetch starts iff `tgt` < `V_ACTIVE` and `tgt[CELL_SHIFT-1:0]` == 0.
  - Fetched row = `tgt>>CELL_SHIFT`.
- Row base address:
  - No multiplier. `base` is a register.
  - Cleared to 0 when `tgt` == 0; otherwise incremented by `GRID_W` at each fetch start.
- FSM states:
  - **IDLE:**
    - On a qualifying `line_pulse`: go to FETCH and clear `col`.
  - **FETCH:**
    - Drive `ram_addr` = `base`+`col` with `ram_we`=0. Increment `col`.
    - The read data returned one cycle later is written to `linebuf[col-1]`.
    - When `col` == `GRID_W`-1 has been issued: go to DRAIN.
  - **DRAIN:**
    - Capture the last word into `linebuf[GRID_W-1]`, then go to IDLE.
- Arbitration:
  - The display path has absolute priority.
  - `sim_gnt` = `sim_req` && state==IDLE && no qualifying `line_pulse` this cycle. The pulse wins a same-cycle tie.
  - A granted sim access drives `ram_addr`/`ram_we`/`ram_wdata` directly from the `sim_*` inputs.
  - For a granted read, `sim_rdata` = `ram_rdata` with `sim_rvalid`=1 on the next cycle.
  - The sim engine holds its request until granted.
- Display stream:
  - `linebuf` index = `DrawX>>CELL_SHIFT`.
  - The render outputs are registered from `linebuf`.
  - While `vga_blank`=1, they register all-zero.
- Overrun:
  - A qualifying `line_pulse` while in FETCH or DRAIN restarts the fetch for the new row and sets `fetch_overrun`.
  - `fetch_overrun` is cleared only by reset.
- `line_pulse` with a non-qualifying `tgt` is ignored in every state.

## Timing
- Reset values:
  - State IDLE; `col`=0; `base`=0.
  - `sim_gnt`, `sim_rvalid`, `ram_we`, `fetch_overrun` = 0.
  - `ram_addr`, `ram_wdata`, `sim_rdata` = 0.
  - All render outputs = 0.
  - `linebuf` contents are not reset.
- Fetch duration: `GRID_W`+1 cycles (81) from the cycle after `line_pulse`. It must fit in horizontal blank (≥160 cycles), so `linebuf` is never read mid-fetch.
- Render latency: outputs correspond to `DrawX`/`DrawY`/`vga_blank` sampled 1 cycle earlier. The VGA controller delays sync by 1 cycle to match.
- Sim latency:
  - Write takes effect in the grant cycle.
  - Read data arrives exactly 1 cycle after grant.
  - Worst-case grant wait: `GRID_W`+2 cycles.
- `Reset_n` asserted mid-fetch: immediate return to IDLE, outputs to their reset values. The row is re-fetched only at the next qualifying `line_pulse`.

## Structure
- Add to `params.sv`:
  - `cell_t` packed struct and `CELL_bits`.
  - `CELL_SHIFT`, `GRID_W`, `GRID_H`, `V_TOTAL`.
  - FSM enum `fetch_state_t` {IDLE, FETCH, DRAIN}.
- One sub-module: `render_line_buffer`.
  - `GRID_W` × `CELL_bits`.
  - One write port and one registered read port, inferred as distributed RAM.
- Arbitration mux and FSM live in the top module.

## Test plan
1. **First-row fetch.** Reset, preload RAM[i]=i. Pulse `line_pulse` with `DrawY`=524.
   - Expect reads of addresses 0..79.
   - On line 0 at `DrawX`=16, `renderChem` = 2 one cycle later.
2. **Row advance.** `line_pulse` at `DrawY`=7, then 15.
   - Expect `base` = 80, then 160.
   - `DrawY`=6 pulse → no fetch.
   - `DrawY`=479 pulse → no fetch.
3. **Arbitration.** Hold `sim_req`=1 read at addr 42 across a fetch.
   - `sim_gnt`=0 for 82 cycles from the pulse cycle.
   - Then grant; `sim_rvalid` with RAM[42] on the next cycle.
4. **Sim write then display.** Sim writes {ant=1,…} to addr 81, then row 1 is fetched.
   - At line 8, `DrawX`=8: `renderAnt`=1.
5. **Overrun.** Second qualifying `line_pulse` 40 cycles into a fetch.
   - `fetch_overrun`=1.
   - Fetch restarts with `col`=0 at the new base.
6. **Async reset.** Drop `Reset_n` mid-FETCH without a clock edge.
   - State IDLE, `ram_we`=0, render outputs 0 immediately.
